int_request_controller: RTL and testbench

//  Upstream feeder for the Processor's int/ack interrupt handshake.

---
 rtl/int_request_controller.sv | 140 ++++++++++++++
 tb/tb_int_request_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_request_controller.sv
// Interrupt request feeder: synchronises irq lines, latches rising edges, fixed-priority grant with ack/hold-off.
// Optional INT_MASK_EN adds irq_mask (1 = masked, still latched as pending, excluded from arbitration).
module int_request_controller #(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned ID_W           = 2,
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
`ifdef INT_MASK_EN
    input  logic [NUM_SRC-1:0] irq_mask,
`endif
    input  logic               ack,
    output logic               int_out,
    output logic [ID_W-1:0]    int_id,
    output logic [NUM_SRC-1:0] pending,
    output logic               busy
);

    localparam int unsigned CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int unsigned CNT_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] s1_q, s2_q, s3_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] rise, clr, eligible;
    logic               int_out_q, int_out_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    winner;
    logic               found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= irq_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

`ifdef INT_MASK_EN
    // Mask is registered so an unmask takes effect on the following cycle.
    logic [NUM_SRC-1:0] mask_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mask_q <= '0;
        else        mask_q <= irq_mask;
    end
    assign eligible = pending_q & ~mask_q;
`else
    assign eligible = pending_q;
`endif

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && !found) begin
                found  = 1'b1;
                winner = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        int_out_d = int_out_q;
        int_id_d  = int_id_q;
        cnt_d     = cnt_q;
        clr       = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = REQ;
                    int_out_d = 1'b1;
                    int_id_d  = winner;
                end
            end
            REQ: begin
                if (ack) begin
                    int_out_d = 1'b0;
                    for (int unsigned i = 0; i < NUM_SRC; i++) begin
                        if (ID_W'(i) == int_id_q) clr[i] = 1'b1;
                    end
                    if (HOLDOFF_CYCLES > 0) begin
                        state_d = HOLD;
                        cnt_d   = CNT_W'(CNT_LOAD);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A fresh edge on the source being cleared wins over the clear.
        pending_d = (pending_q & ~clr) | rise;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            int_out_q <= 1'b0;
            int_id_q  <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            int_out_q <= int_out_d;
            int_id_q  <= int_id_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    assign int_out = int_out_q;
    assign int_id  = int_id_q;
    assign pending = pending_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_int_request_controller.sv
// Self-checking bench for int_request_controller: vector table, directed corner sequences, random vs. reference model.
module tb_int_request_controller;

    localparam int NSRC = 4;
    localparam int HOLD = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NSRC-1:0] irq_in = '0;
    logic            ack = 1'b0;
    logic            int_out;
    logic [1:0]      int_id;
    logic [NSRC-1:0] pending;
    logic            busy;
`ifdef INT_MASK_EN
    logic [NSRC-1:0] irq_mask = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int_request_controller #(
        .NUM_SRC(NSRC),
        .ID_W(2),
        .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .irq_in(irq_in),
`ifdef INT_MASK_EN
        .irq_mask(irq_mask),
`endif
        .ack(ack),
        .int_out(int_out),
        .int_id(int_id),
        .pending(pending),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        irq_in = '0;
        ack    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Reference model: pending set from the line value seen two and three samples back.
    logic [NSRC-1:0] hist [3];
    logic [NSRC-1:0] m_pend;
    bit              m_int;
    int              m_id;
    int              m_wait;
    bit              m_busy;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) hist[i] = '0;
        m_pend = '0;
        m_int  = 0;
        m_id   = 0;
        m_wait = 0;
        m_busy = 0;
    endtask

    task automatic model_step(input logic [NSRC-1:0] irq, input logic a);
        logic [NSRC-1:0] rose;
        logic [NSRC-1:0] clear;
        rose  = hist[1] & ~hist[2];
        clear = '0;
        if (m_int) begin
            if (a) begin
                clear[m_id] = 1'b1;
                m_int  = 0;
                m_wait = HOLD;
            end
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (m_pend != 0) begin
            for (int i = NSRC - 1; i >= 0; i--) if (m_pend[i]) m_id = i;
            m_int = 1;
        end
        m_busy  = m_int || (m_wait > 0);
        m_pend  = (m_pend & ~clear) | rose;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = irq;
    endtask

    typedef struct {
        logic [NSRC-1:0] irq;
        logic            a;
        logic            e_int;
        logic [1:0]      e_id;
        logic [NSRC-1:0] e_pend;
        logic            e_busy;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [NSRC-1:0] r_irq;
        logic            r_ack;
        int              waited;

        vt[0]  = '{4'hA, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        vt[1]  = '{4'hA, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        vt[2]  = '{4'hA, 1'b0, 1'b0, 2'd0, 4'hA, 1'b0};
        vt[3]  = '{4'hA, 1'b0, 1'b1, 2'd1, 4'hA, 1'b1};
        vt[4]  = '{4'hA, 1'b1, 1'b0, 2'd0, 4'h8, 1'b1};
        vt[5]  = '{4'hA, 1'b0, 1'b0, 2'd0, 4'h8, 1'b1};
        vt[6]  = '{4'hA, 1'b0, 1'b0, 2'd0, 4'h8, 1'b0};
        vt[7]  = '{4'hA, 1'b0, 1'b1, 2'd3, 4'h8, 1'b1};
        vt[8]  = '{4'hA, 1'b1, 1'b0, 2'd0, 4'h0, 1'b1};
        vt[9]  = '{4'hA, 1'b0, 1'b0, 2'd0, 4'h0, 1'b1};
        vt[10] = '{4'hA, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};
        vt[11] = '{4'h0, 1'b0, 1'b0, 2'd0, 4'h0, 1'b0};

        // Reset with all lines high
        reset  = 1'b0;
        irq_in = 4'hF;
        tick();
        tick();
        chk("rst_int_out", 32'(int_out), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_release_pending", 32'(pending), 32'hF);

        // Single source with long ack delay
        do_reset();
        irq_in = 4'b0100;
        tick(); tick(); tick();
        chk("single_pend_e3", 32'(pending), 32'h4);
        chk("single_int_e3", 32'(int_out), 0);
        tick();
        chk("single_int_e4", 32'(int_out), 1);
        chk("single_id_e4", 32'(int_id), 2);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("single_hold_int", 32'(int_out), 1);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("single_ack_pend", 32'(pending), 0);
        chk("single_ack_int", 32'(int_out), 0);

        // Priority table
        do_reset();
        for (int i = 0; i < 12; i++) begin
            irq_in = vt[i].irq;
            ack    = vt[i].a;
            tick();
            chk($sformatf("vec%0d_int", i), 32'(int_out), 32'(vt[i].e_int));
            chk($sformatf("vec%0d_pend", i), 32'(pending), 32'(vt[i].e_pend));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
            if (vt[i].e_int) chk($sformatf("vec%0d_id", i), 32'(int_id), 32'(vt[i].e_id));
        end
        ack = 1'b0;

        // No pre-emption
        do_reset();
        irq_in = 4'b0100;
        tick(); tick(); tick(); tick();
        chk("nopre_grant_id", 32'(int_id), 2);
        irq_in = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("nopre_int", 32'(int_out), 1);
            chk("nopre_id", 32'(int_id), 2);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("nopre_ack_int", 32'(int_out), 0);
        tick();
        chk("nopre_gap1", 32'(int_out), 0);
        tick();
        chk("nopre_gap2", 32'(int_out), 0);
        tick();
        chk("nopre_next_int", 32'(int_out), 1);
        chk("nopre_next_id", 32'(int_id), 0);

        // Set wins over clear on the ack cycle
        do_reset();
        irq_in = 4'b0010;
        tick(); tick(); tick(); tick();
        chk("setwins_grant_id", 32'(int_id), 1);
        irq_in = 4'b0000;
        tick(); tick(); tick();
        irq_in = 4'b0010;
        tick(); tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("setwins_pend", 32'(pending[1]), 1);
        chk("setwins_int_low", 32'(int_out), 0);
        waited = 0;
        while (int_out !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        chk("setwins_regrant_wait", 32'(waited), 3);
        chk("setwins_regrant_id", 32'(int_id), 1);

        // Reset mid-REQ drops everything immediately
        reset = 1'b0;
        #1;
        chk("midreq_rst_int", 32'(int_out), 0);
        chk("midreq_rst_pend", 32'(pending), 0);
        chk("midreq_rst_busy", 32'(busy), 0);
        tick();
        reset = 1'b1;

`ifdef INT_MASK_EN
        do_reset();
        irq_mask = 4'b0001;
        irq_in   = 4'b0001;
        tick(); tick(); tick();
        chk("mask_pend", 32'(pending[0]), 1);
        tick(); tick();
        chk("mask_int_blocked", 32'(int_out), 0);
        irq_mask = 4'b0000;
        tick();
        chk("unmask_e1_int", 32'(int_out), 0);
        tick();
        chk("unmask_e2_int", 32'(int_out), 1);
        chk("unmask_e2_id", 32'(int_id), 0);
        irq_in = '0;
`endif

        // Randomised run against the reference model
        do_reset();
        model_reset();
        r_irq = '0;
        for (int c = 0; c < 700; c++) begin
            for (int b = 0; b < NSRC; b++) begin
                if ($urandom_range(0, 5) == 0) r_irq[b] = ~r_irq[b];
            end
            r_ack  = ($urandom_range(0, 2) == 0);
            irq_in = r_irq;
            ack    = r_ack;
            tick();
            model_step(r_irq, r_ack);
            chk("rnd_int", 32'(int_out), 32'(m_int));
            chk("rnd_pend", 32'(pending), 32'(m_pend));
            chk("rnd_busy", 32'(busy), 32'(m_busy));
            if (m_int) chk("rnd_id", 32'(int_id), 32'(m_id));
        end
        ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
